// File: rtl/uart_rx_frame_parser_if.sv
// Byte-stream input and framed-command output bundle for the UART frame parser.
// The parser side uses modport master; the badge control logic (or a bench) uses slave.
interface uart_rx_frame_parser_if #(
  parameter int DBITS   = 8,
  parameter int MAX_LEN = 4
);
  logic                     rx_byte_valid;
  logic [DBITS-1:0]         rx_byte;
  logic                     frame_valid;
  logic                     frame_ready;
  logic [DBITS-1:0]         frame_cmd;
  logic [2:0]               frame_len;
  logic [DBITS*MAX_LEN-1:0] frame_payload;
  logic                     frame_err;
  logic [2:0]               err_code;

  modport master (
    input  rx_byte_valid, rx_byte, frame_ready,
    output frame_valid, frame_cmd, frame_len, frame_payload, frame_err, err_code
  );

  modport slave (
    output rx_byte_valid, rx_byte, frame_ready,
    input  frame_valid, frame_cmd, frame_len, frame_payload, frame_err, err_code
  );
endinterface

// File: rtl/uart_rx_frame_parser.sv
// Frames a UART byte stream into SYNC/CMD/LEN/payload/CHK packets, checks them and
// presents good frames on a valid/ready register; dropped frames raise a coded error pulse.
module uart_rx_frame_parser #(
  parameter int               DBITS     = 8,
  parameter int               MAX_LEN   = 4,
  parameter logic [DBITS-1:0] SYNC_BYTE = 8'hA5,
  parameter int               TIMEOUT   = 215360,
  parameter int               TO_BITS   = 18
) (
  input  logic                    clk_100MHz,
  input  logic                    reset,
  uart_rx_frame_parser_if.master  bus
);
  localparam int               IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [DBITS-1:0] MAX_LEN_B = DBITS'(MAX_LEN);
  localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT - 1);
  localparam logic [2:0] E_LEN = 3'd1, E_CHK = 3'd2, E_TO = 3'd3, E_OVR = 3'd4;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_LEN, S_PAY, S_CHK} state_t;

  state_t                         state_q, state_d;
  logic [DBITS-1:0]               cmd_q, chk_q;
  logic [2:0]                     len_q;
  logic [IW-1:0]                  idx_q;
  logic [MAX_LEN-1:0][DBITS-1:0]  pay_q;
  logic [TO_BITS-1:0]             to_cnt;

  logic             vld;
  logic [DBITS-1:0] rx;
  logic             len_bad, timeout_hit, last_pay;
  logic             done, err_set;
  logic [2:0]       err_val;

  assign vld         = bus.rx_byte_valid;
  assign rx          = bus.rx_byte;
  assign len_bad     = rx > MAX_LEN_B;
  // An arriving byte always beats the timeout in the same cycle.
  assign timeout_hit = (state_q != S_IDLE) && !vld && (to_cnt == TO_LAST);
  assign last_pay    = 3'(idx_q) == (len_q - 3'd1);

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout_hit) begin
      state_d = S_IDLE;
    end else if (vld) begin
      case (state_q)
        S_IDLE:  if (rx == SYNC_BYTE) state_d = S_CMD;
        S_CMD:   state_d = S_LEN;
        S_LEN:   state_d = len_bad ? S_IDLE : ((rx == '0) ? S_CHK : S_PAY);
        S_PAY:   if (last_pay) state_d = S_CHK;
        S_CHK:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    done    = 1'b0;
    err_set = 1'b0;
    err_val = E_LEN;
    if (timeout_hit) begin
      err_set = 1'b1;
      err_val = E_TO;
    end else if (vld) begin
      case (state_q)
        S_LEN: if (len_bad) begin
          err_set = 1'b1;
          err_val = E_LEN;
        end
        S_CHK: if (rx != chk_q) begin
          err_set = 1'b1;
          err_val = E_CHK;
        end else if (bus.frame_valid && !bus.frame_ready) begin
          err_set = 1'b1;
          err_val = E_OVR;
        end else begin
          done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      cmd_q  <= '0;
      chk_q  <= '0;
      len_q  <= '0;
      idx_q  <= '0;
      pay_q  <= '0;
      to_cnt <= '0;
    end else begin
      if (vld || state_q == S_IDLE || timeout_hit) to_cnt <= '0;
      else                                         to_cnt <= to_cnt + 1'b1;
      if (vld) begin
        case (state_q)
          S_CMD: begin
            cmd_q <= rx;
            chk_q <= rx;
          end
          S_LEN: if (!len_bad) begin
            len_q <= rx[2:0];
            chk_q <= chk_q ^ rx;
            pay_q <= '0;
            idx_q <= '0;
          end
          S_PAY: begin
            chk_q <= chk_q ^ rx;
            idx_q <= idx_q + 1'b1;
            for (int i = 0; i < MAX_LEN; i++)
              if (idx_q == IW'(i)) pay_q[i] <= rx;
          end
          default: ;
        endcase
      end
    end
  end

  // Output register: a consumed frame may be replaced in the same cycle.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      bus.frame_valid   <= 1'b0;
      bus.frame_cmd     <= '0;
      bus.frame_len     <= '0;
      bus.frame_payload <= '0;
      bus.frame_err     <= 1'b0;
      bus.err_code      <= '0;
    end else begin
      bus.frame_err <= err_set;
      if (err_set) bus.err_code <= err_val;
      if (done) begin
        bus.frame_valid   <= 1'b1;
        bus.frame_cmd     <= cmd_q;
        bus.frame_len     <= len_q;
        bus.frame_payload <= pay_q;
      end else if (bus.frame_valid && bus.frame_ready) begin
        bus.frame_valid <= 1'b0;
      end
    end
  end
endmodule
